// File: rtl/mips_bus_initiator.sv
// rtl/mips_bus_initiator.sv - MIPS sub-word load/store initiator for a word-addressed waitrequest bus
// One command in flight; lane steering, load extension and a stall timeout.
module mips_bus_initiator #(
   parameter int TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_write,
   input  logic [1:0]  i_cmd_size,
   input  logic        i_cmd_signed,
   input  logic [31:0] i_cmd_addr,
   input  logic [31:0] i_cmd_wdata,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_error,
   output logic [31:0] o_address,
   output logic        o_read,
   output logic        o_write,
   output logic [3:0]  o_byteenable,
   output logic [31:0] o_writedata,
   input  logic        i_waitrequest,
   input  logic [31:0] i_readdata
);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RDATA, S_RESP, S_ERR} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [29:0] r_waddr;
   logic        r_write;
   logic        r_signed;
   logic [1:0]  r_size;
   logic [1:0]  r_off;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [7:0]  r_stall;

   logic        w_accept;
   logic        w_illegal;
   logic        w_timeout;
   logic [1:0]  w_off;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_shifted;
   logic [31:0] w_ext;

   assign w_off    = i_cmd_addr[1:0];
   assign w_accept = (r_state == S_IDLE) && i_cmd_valid;

   always_comb begin
      w_illegal = 1'b0;
      w_be      = 4'b1111;
      case (i_cmd_size)
         2'b00:   w_be = 4'b0001 << w_off;
         2'b01: begin
            w_be      = w_off[1] ? 4'b1100 : 4'b0011;
            w_illegal = w_off[0];
         end
         2'b10:   w_illegal = (w_off != 2'b00);
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_wdata = (i_cmd_wdata << {w_off, 3'b000}) &
                    {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

   assign w_shifted = i_readdata >> {r_off, 3'b000};

   always_comb begin
      case (r_size)
         2'b00:   w_ext = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
         2'b01:   w_ext = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
         default: w_ext = w_shifted;
      endcase
   end

   // Compare count+1 so the stall that reaches TIMEOUT is also the last strobe cycle.
   assign w_timeout = (TIMEOUT != 0) && (({1'b0, r_stall} + 9'd1) == 9'(TIMEOUT));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_cmd_valid) w_next = w_illegal ? S_ERR : S_REQ;
         S_REQ: begin
            if (!i_waitrequest)  w_next = r_write ? S_RESP : S_RDATA;
            else if (w_timeout)  w_next = S_ERR;
         end
         S_RDATA: w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_waddr  <= '0;
         r_write  <= 1'b0;
         r_signed <= 1'b0;
         r_size   <= 2'b00;
         r_off    <= 2'b00;
         r_be     <= 4'b0000;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_stall  <= '0;
      end else begin
         if (w_accept) begin
            r_waddr  <= i_cmd_addr[31:2];
            r_write  <= i_cmd_write;
            r_signed <= i_cmd_signed;
            r_size   <= i_cmd_size;
            r_off    <= w_off;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_rdata  <= '0;
            r_stall  <= '0;
         end else if ((r_state == S_REQ) && i_waitrequest) begin
            r_stall  <= r_stall + 8'd1;
         end
         if (r_state == S_RDATA) r_rdata <= w_ext;
      end
   end

   always_comb begin
      o_cmd_ready  = (r_state == S_IDLE);
      o_read       = (r_state == S_REQ) && !r_write;
      o_write      = (r_state == S_REQ) && r_write;
      o_rsp_valid  = (r_state == S_RESP) || (r_state == S_ERR);
      o_rsp_error  = (r_state == S_ERR);
      o_rsp_rdata  = r_rdata;
      o_address    = {r_waddr, 2'b00};
      o_byteenable = r_be;
      o_writedata  = r_wdata;
   end
endmodule

// File: tb/tb_mips_bus_initiator.sv
// tb/tb_mips_bus_initiator.sv - directed bench with a per-cycle transaction model for mips_bus_initiator
// Each command's expected timeline is derived from size/offset arithmetic and checked every cycle.
module tb_mips_bus_initiator;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_write, cmd_signed;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        o_cmd_ready, o_rsp_valid, o_rsp_error, o_read, o_write;
   logic [31:0] o_rsp_rdata, o_address, o_writedata;
   logic [3:0]  o_byteenable;
   logic        waitrequest;
   logic [31:0] readdata;

   mips_bus_initiator #(.TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_write(cmd_write), .i_cmd_size(cmd_size), .i_cmd_signed(cmd_signed),
      .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
      .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_error(o_rsp_error),
      .o_address(o_address), .o_read(o_read), .o_write(o_write),
      .o_byteenable(o_byteenable), .o_writedata(o_writedata),
      .i_waitrequest(waitrequest), .i_readdata(readdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          chk;
      bit          ready;
      bit          rd;
      bit          wr;
      bit          rv;
      bit          re;
      bit          bus;
      bit          rdchk;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rdata;
   } exp_t;

   exp_t        ex [0:1023];
   exp_t        e;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [3:0]  cap_be;
   logic [31:0] cap_wd;
   logic [31:0] cap_rd;
   logic        cap_err;
   int          cap_cyc;

   function automatic exp_t mk(input bit ready, input bit rv, input bit re);
      exp_t t;
      t.chk = 1'b1; t.ready = ready; t.rd = 1'b0; t.wr = 1'b0;
      t.rv = rv; t.re = re; t.bus = 1'b0; t.rdchk = rv;
      t.addr = '0; t.be = '0; t.wd = '0; t.rdata = '0;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && cyc < 1024 && ex[cyc].chk) begin
         e = ex[cyc];
         chk("cmd_ready", 32'(o_cmd_ready), 32'(e.ready));
         chk("read", 32'(o_read), 32'(e.rd));
         chk("write", 32'(o_write), 32'(e.wr));
         chk("rsp_valid", 32'(o_rsp_valid), 32'(e.rv));
         chk("rsp_error", 32'(o_rsp_error), 32'(e.re));
         if (e.bus) begin
            chk("address", o_address, e.addr);
            chk("byteenable", 32'(o_byteenable), 32'(e.be));
            if (e.wr) chk("writedata", o_writedata, e.wd);
         end
         if (e.rdchk) chk("rsp_rdata", o_rsp_rdata, e.rdata);
      end
      if (o_read || o_write) cap_be = o_byteenable;
      if (o_write) cap_wd = o_writedata;
      if (o_rsp_valid) begin
         cap_rd  = o_rsp_rdata;
         cap_err = o_rsp_error;
         cap_cyc = cyc;
      end
   end

   // Called at a falling edge while the initiator is idle; returns at the falling edge after the response.
   task automatic run_cmd(input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] ad, input logic [31:0] wdat, input logic [31:0] rbus,
                          input int stalls, input int lit_lat, input logic [3:0] lit_be,
                          input logic [31:0] lit_wd, input logic [31:0] lit_rd, input bit lit_err);
      int          c0, n, off, ns, last;
      bit          legal, tmo;
      longint      m, v;
      logic [3:0]  be;
      logic [31:0] wd, rd;
      c0    = cyc;
      off   = int'(ad[1:0]);
      n     = 1 << sz;
      legal = (sz != 2'b11) && (off % n == 0);
      m     = legal ? ((longint'(1) << (8 * n)) - 1) : 0;
      be    = 4'(((1 << n) - 1) << off);
      wd    = 32'((longint'({32'd0, wdat}) & m) << (8 * off));
      v     = (longint'({32'd0, rbus}) >> (8 * off)) & m;
      if (sg && n < 4 && v > m / 2) v = v - (m + 1);
      rd    = 32'(v);
      tmo   = legal && TMO != 0 && stalls >= TMO;
      ns    = tmo ? TMO : stalls + 1;

      if (!legal) begin
         last = c0 + 1;
         ex[last] = mk(0, 1, 1);
      end else begin
         for (int k = 1; k <= ns; k++) begin
            ex[c0 + k]      = mk(0, 0, 0);
            ex[c0 + k].rd   = !wr;
            ex[c0 + k].wr   = wr;
            ex[c0 + k].bus  = 1'b1;
            ex[c0 + k].addr = {ad[31:2], 2'b00};
            ex[c0 + k].be   = be;
            ex[c0 + k].wd   = wd;
         end
         if (tmo) begin
            last = c0 + ns + 1;
            ex[last] = mk(0, 1, 1);
         end else if (wr) begin
            last = c0 + ns + 1;
            ex[last] = mk(0, 1, 0);
         end else begin
            ex[c0 + ns + 1] = mk(0, 0, 0);
            last = c0 + ns + 2;
            ex[last] = mk(0, 1, 0);
            ex[last].rdata = rd;
         end
      end

      cap_be = '0; cap_wd = '0; cap_rd = 32'hFFFF_FFFF; cap_err = 1'b0; cap_cyc = -1;
      cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_signed = sg;
      cmd_addr = ad; cmd_wdata = wdat;
      readdata = ~rbus;
      for (int k = 1; k <= last - c0 + 1; k++) begin
         @(negedge clk);
         cmd_valid   = 1'b0;
         waitrequest = legal && k <= ns && k <= stalls;
         readdata    = (legal && !wr && !tmo && k == ns + 1) ? rbus : ~rbus;
      end
      waitrequest = 1'b0;
      chk("latency", 32'(cap_cyc - c0), 32'(lit_lat));
      chk("lit_byteenable", 32'(cap_be), 32'(lit_be));
      chk("lit_writedata", cap_wd, lit_wd);
      chk("lit_rsp_rdata", cap_rd, lit_rd);
      chk("lit_rsp_error", 32'(cap_err), 32'(lit_err));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      for (int i = 0; i < 1024; i++) ex[i] = mk(1, 0, 0);
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00; cmd_signed = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; waitrequest = 1'b0; readdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
      chk("rst_rsp_error", 32'(o_rsp_error), 32'd0);
      chk("rst_address", o_address, 32'd0);
      chk("rst_read", 32'(o_read), 32'd0);
      chk("rst_write", 32'(o_write), 32'd0);
      chk("rst_byteenable", 32'(o_byteenable), 32'd0);
      chk("rst_writedata", o_writedata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      //       wr sz     sg addr      wdata         readdata      st lat be     writedata     rsp_rdata     err
      run_cmd(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 4'hF, 32'hDEADBEEF, 32'h0,        0);
      run_cmd(1, 2'd0, 0, 32'h13, 32'h000000A5, 32'h0,        0, 2, 4'h8, 32'hA5000000, 32'h0,        0);
      run_cmd(0, 2'd0, 1, 32'h13, 32'h0,        32'hA5000000, 0, 3, 4'h8, 32'h0,        32'hFFFFFFA5, 0);
      run_cmd(0, 2'd1, 0, 32'h22, 32'h0,        32'h80011234, 0, 3, 4'hC, 32'h0,        32'h00008001, 0);
      run_cmd(0, 2'd1, 1, 32'h22, 32'h0,        32'h80011234, 0, 3, 4'hC, 32'h0,        32'hFFFF8001, 0);
      run_cmd(0, 2'd2, 0, 32'h40, 32'h0,        32'h12345678, 3, 6, 4'hF, 32'h0,        32'h12345678, 0);
      run_cmd(0, 2'd2, 0, 32'h41, 32'h0,        32'h12345678, 0, 1, 4'h0, 32'h0,        32'h0,        1);
      run_cmd(0, 2'd1, 0, 32'h03, 32'h0,        32'h12345678, 0, 1, 4'h0, 32'h0,        32'h0,        1);
      run_cmd(1, 2'd3, 0, 32'h00, 32'h12345678, 32'h0,        0, 1, 4'h0, 32'h0,        32'h0,        1);
      run_cmd(1, 2'd1, 0, 32'h22, 32'h1234BEEF, 32'h0,        1, 3, 4'hC, 32'hBEEF0000, 32'h0,        0);
      run_cmd(1, 2'd0, 0, 32'h11, 32'hFFFFFF5A, 32'h0,        0, 2, 4'h2, 32'h00005A00, 32'h0,        0);
      run_cmd(0, 2'd0, 1, 32'h11, 32'h0,        32'h00007F00, 0, 3, 4'h2, 32'h0,        32'h0000007F, 0);
      run_cmd(0, 2'd2, 0, 32'h80, 32'h0,        32'h0,      100, 5, 4'hF, 32'h0,        32'h0,        1);
      run_cmd(0, 2'd2, 1, 32'h40, 32'h0,        32'h87654321, 3, 6, 4'hF, 32'h0,        32'h87654321, 0);

      // Reset pulse while a stalled read is on the bus.
      c0 = cyc;
      for (int k = 1; k <= 3; k++) ex[c0 + k].chk = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'd2; cmd_signed = 1'b0;
      cmd_addr = 32'h80; waitrequest = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("pre_reset_read", 32'(o_read), 32'd1);
      chk("pre_reset_address", o_address, 32'h80);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_read", 32'(o_read), 32'd0);
      chk("async_reset_write", 32'(o_write), 32'd0);
      chk("async_reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; waitrequest = 1'b0;
      repeat (4) @(negedge clk);
      chk("post_reset_cmd_ready", 32'(o_cmd_ready), 32'd1);
      run_cmd(1, 2'd2, 0, 32'h44, 32'hCAFEF00D, 32'h0, 0, 2, 4'hF, 32'hCAFEF00D, 32'h0, 0);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mips_bus_initiator.md
# mips_bus_initiator

Synthesizable bus initiator for the MIPS memory bus, which is word-addressed and uses `waitrequest` stalls. It accepts one load/store command at a time on a valid/ready interface and converts MIPS sub-word semantics into bus signals:

- byte, half and word sizes;
- sign or zero extension on loads;
- byte-lane steering.

It then drives `address`/`read`/`write`/`byteenable`/`writedata` towards a memory responder and returns one response per command. It sits between loader/DMA-style logic and the same memory responders the CPU talks to.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of consecutive stalled cycles before the transfer aborts. Legal range 0..255; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: initiator can accept a command.
- `cmd_write` in 1: 1 = store, 0 = load.
- `cmd_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `cmd_signed` in 1: sign-extend loads of byte or half size.
- `cmd_addr` in 32: byte address.
- `cmd_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_error` out 1: set on misalignment, illegal size or timeout.
- `address` out 32: word-aligned bus address, `{cmd_addr[31:2], 2'b00}`.
- `read` out 1: bus read strobe.
- `write` out 1: bus write strobe.
- `byteenable` out 4: bit k enables byte lane k, which is data bits [8k+7:8k].
- `writedata` out 32: lane-steered store data.
- `waitrequest` in 1: responder stall.
- `readdata` in 32: valid on the cycle after a read is accepted.

## Operation
- Lanes are little-endian. The byte offset is o = `cmd_addr[1:0]`.
  - Byte: `byteenable` = 1<<o.
  - Half: `byteenable` = 0011 (o=0) or 1100 (o=2).
  - Word: `byteenable` = 1111.
- Store data is `cmd_wdata` shifted left by 8·o bits. Unused lanes are driven 0.
- Load data is `readdata` shifted right by 8·o bits and truncated to the size, then extended:
  - sign-extended if `cmd_signed` and the size is byte or half;
  - zero-extended otherwise;
  - word loads ignore `cmd_signed`.
- Error conditions:
  - half with o odd;
  - word with o ≠ 0;
  - size 11.
  
  An erroring command issues no bus cycle.
- State machine, all outputs registered:
  - **IDLE**: `cmd_ready`=1. When `cmd_valid` is high, latch all command fields. Go to ERR if the command is illegal, else to REQ.
  - **REQ**: assert `read` or `write` with `address`, `byteenable` and `writedata`.
    - `waitrequest`=0 at the edge: transfer accepted. A write goes to RESP; a read goes to RDATA.
    - `waitrequest`=1: increment the stall counter. If `TIMEOUT`≠0 and the count reaches `TIMEOUT`, drop the strobe and go to ERR.
  - **RDATA**: strobes low; capture and extend `readdata`; go to RESP.
  - **RESP**: `rsp_valid`=1 and `rsp_error`=0 for one cycle; go to IDLE.
  - **ERR**: `rsp_valid`=1, `rsp_error`=1 and `rsp_rdata`=0 for one cycle; go to IDLE.
- The stall counter clears on every entry to REQ.
- `read` and `write` are never high together.
- Bus outputs hold stable while `waitrequest` is high.
- There is no response back-pressure: the consumer must take `rsp_valid` in the cycle it is asserted.

## Timing
- **Reset value of every output**: `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `address`=0, `read`=0, `write`=0, `byteenable`=0, `writedata`=0. The state resets to IDLE and the stall counter to 0.
- Reset asserted mid-transfer drops the strobes asynchronously. No response is produced for the aborted command.
- **Latency with no stalls**, counting from the command-accept edge at cycle 0:
  - store: strobe in cycle 1, `rsp_valid` in cycle 2;
  - load: strobe in cycle 1, `readdata` sampled at the end of cycle 2, `rsp_valid` in cycle 3;
  - illegal command: `rsp_valid` in cycle 1.
- Each stall cycle adds one cycle of latency.
- A timeout with `TIMEOUT`=N: the strobe is high for N cycles, then ERR.
- `cmd_ready` is low from the cycle after acceptance until the cycle after the response. The next command can therefore be accepted in the cycle following `rsp_valid`.

## Test plan
- Store word 0xDEADBEEF to 0x10, no stalls:
  - `write`=1 in cycle 1 with `address`=0x10, `byteenable`=1111, `writedata`=0xDEADBEEF;
  - `rsp_valid`=1 with `rsp_error`=0 in cycle 2.
- Store byte 0xA5 to 0x13:
  - `address`=0x10, `byteenable`=1000, `writedata`=0xA5000000.
  
  Then load signed byte from 0x13 with `readdata`=0xA5000000: `rsp_rdata`=0xFFFFFFA5 in cycle 3.
- Load unsigned half from 0x22 with `readdata`=0x8001xxxx: `byteenable`=1100 and `rsp_rdata`=0x00008001. The same command signed gives 0xFFFF8001.
- Load word from 0x40 with `waitrequest` held high for 3 cycles:
  - strobe held 4 cycles with `address` stable;
  - `rsp_valid` in cycle 6;
  - `rsp_rdata` = `readdata`.
- Misalignment and illegal size:
  - word at 0x41 → no `read`/`write` ever asserted; `rsp_valid`=1, `rsp_error`=1 and `rsp_rdata`=0 in cycle 1;
  - half at 0x03 and size 11 give the same result.
- `TIMEOUT`=4 with `waitrequest` stuck high: the strobe is high for exactly 4 cycles, then an error response. Separately, a reset pulse during REQ drops `read` immediately, gives no `rsp_valid`, and `cmd_ready`=1 after release.
